// File: rtl/mmio_bus_fabric.sv
// mmio_bus_fabric: memory-mapped I/O interconnect between one bus master and
// NUM_SLAVES peripheral slots. Request/done handshake, slot decode, one-hot
// per-slave read/write strobes, configurable read latency, error response on
// unmapped addresses.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   m_req/m_we/m_addr/m_wdata   master request (sampled only in IDLE)
//   m_busy/m_done/m_err/m_rdata master response
//   memAddress/writeData        latched address/data broadcast to all slaves
//   writeEnable/readEnable      one-hot slave strobes (one cycle, ACCESS only)
//   s_readData                  slave i read data at [i*DATA_W +: DATA_W]
//   stat_xfers/stat_errs        transaction/error counters
//
// Optional feature: define MMIO_STATS_EN to build saturating transaction and
// error counters; otherwise both stat outputs are tied to 0.

module mmio_bus_fabric #(
  parameter int unsigned       NUM_SLAVES   = 4,
  parameter int unsigned       ADDR_W       = 30,
  parameter int unsigned       DATA_W       = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter int unsigned       SLOT_STRIDE  = 4,
  parameter int unsigned       READ_LATENCY = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m_req,
  input  logic                         m_we,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic [DATA_W-1:0]            m_wdata,
  output logic                         m_busy,
  output logic                         m_done,
  output logic                         m_err,
  output logic [DATA_W-1:0]            m_rdata,
  output logic [ADDR_W-1:0]            memAddress,
  output logic [DATA_W-1:0]            writeData,
  output logic [NUM_SLAVES-1:0]        writeEnable,
  output logic [NUM_SLAVES-1:0]        readEnable,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_readData,
  output logic [15:0]                  stat_xfers,
  output logic [15:0]                  stat_errs
);

  localparam int unsigned SLOT_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned SHIFT  = $clog2(SLOT_STRIDE);
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [2:0] {IDLE, ACCESS, WAIT, DONE, ERR} state_t;

  state_t              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic                we_q, we_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_d, done_d, err_d;
  logic [DATA_W-1:0]   rdata_d, wdata_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [NUM_SLAVES-1:0] wen_d, ren_d;

  logic [ADDR_W-1:0]   off;
  logic                hit;
  logic [SLOT_W-1:0]   slot_sel;
  logic [DATA_W-1:0]   slv_data [NUM_SLAVES];
  logic [DATA_W-1:0]   rd_slice;

  // Unpack the flat slave read bus so the latched slot can index it directly.
  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_unpack
    assign slv_data[i] = s_readData[i*DATA_W +: DATA_W];
  end
  assign rd_slice = slv_data[slot_q];

  // Address decode; an address below BASE_ADDR is rejected before the
  // subtraction result is trusted, so underflow never lands in a slot.
  always_comb begin
    off      = m_addr - BASE_ADDR;
    hit      = (m_addr >= BASE_ADDR) &&
               ((off & ADDR_W'(SLOT_STRIDE - 1)) == '0) &&
               ((off >> SHIFT) < ADDR_W'(NUM_SLAVES));
    slot_sel = SLOT_W'(off >> SHIFT);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = m_rdata;
    addr_d  = memAddress;
    wdata_d = writeData;
    wen_d   = '0;
    ren_d   = '0;

    case (state_q)
      IDLE: begin
        if (m_req) begin
          addr_d  = m_addr;
          wdata_d = m_wdata;
          we_d    = m_we;
          slot_d  = slot_sel;
          if (hit) begin
            state_d = ACCESS;
            if (m_we) wen_d = NUM_SLAVES'(1) << slot_sel;
            else      ren_d = NUM_SLAVES'(1) << slot_sel;
          end else begin
            state_d = ERR;
            done_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end
      ACCESS: begin
        if (we_q || (READ_LATENCY == 0)) begin
          state_d = DONE;
          done_d  = 1'b1;
          if (!we_q) rdata_d = rd_slice;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(READ_LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
          rdata_d = rd_slice;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      m_busy      <= 1'b0;
      m_done      <= 1'b0;
      m_err       <= 1'b0;
      m_rdata     <= '0;
      memAddress  <= '0;
      writeData   <= '0;
      writeEnable <= '0;
      readEnable  <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      m_busy      <= busy_d;
      m_done      <= done_d;
      m_err       <= err_d;
      m_rdata     <= rdata_d;
      memAddress  <= addr_d;
      writeData   <= wdata_d;
      writeEnable <= wen_d;
      readEnable  <= ren_d;
    end
  end

`ifdef MMIO_STATS_EN
  logic [15:0] xfers_q, errs_q;

  // Saturating counters, advanced on each completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfers_q <= '0;
      errs_q  <= '0;
    end else if (m_done) begin
      if (xfers_q != 16'hFFFF)         xfers_q <= xfers_q + 16'd1;
      if (m_err && errs_q != 16'hFFFF) errs_q  <= errs_q + 16'd1;
    end
  end

  assign stat_xfers = xfers_q;
  assign stat_errs  = errs_q;
`else
  assign stat_xfers = '0;
  assign stat_errs  = '0;
`endif

endmodule

// File: tb/tb_mmio_bus_fabric.sv
// Testbench for mmio_bus_fabric: two instances (default zero-latency fabric,
// and a READ_LATENCY=3 fabric at BASE_ADDR 0x100), directed vector table,
// hand sequences for hold/underflow/mid-transaction reset, and randomized
// transactions checked against a behavioural decode/response model.

module tb_mmio_bus_fabric;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         req    [2];
  logic         we_i   [2];
  logic [29:0]  addr_i [2];
  logic [31:0]  wd_i   [2];
  logic [127:0] sd     [2];
  logic         busy   [2];
  logic         done   [2];
  logic         err    [2];
  logic [31:0]  rdata  [2];
  logic [29:0]  maddr  [2];
  logic [31:0]  wdo    [2];
  logic [3:0]   wen    [2];
  logic [3:0]   ren    [2];
  logic [15:0]  sx     [2];
  logic [15:0]  se     [2];

  mmio_bus_fabric dut0 (
    .clk(clk), .rst(rst),
    .m_req(req[0]), .m_we(we_i[0]), .m_addr(addr_i[0]), .m_wdata(wd_i[0]),
    .m_busy(busy[0]), .m_done(done[0]), .m_err(err[0]), .m_rdata(rdata[0]),
    .memAddress(maddr[0]), .writeData(wdo[0]),
    .writeEnable(wen[0]), .readEnable(ren[0]),
    .s_readData(sd[0]), .stat_xfers(sx[0]), .stat_errs(se[0])
  );

  mmio_bus_fabric #(.BASE_ADDR(30'h100), .READ_LATENCY(3)) dut1 (
    .clk(clk), .rst(rst),
    .m_req(req[1]), .m_we(we_i[1]), .m_addr(addr_i[1]), .m_wdata(wd_i[1]),
    .m_busy(busy[1]), .m_done(done[1]), .m_err(err[1]), .m_rdata(rdata[1]),
    .memAddress(maddr[1]), .writeData(wdo[1]),
    .writeEnable(wen[1]), .readEnable(ren[1]),
    .s_readData(sd[1]), .stat_xfers(sx[1]), .stat_errs(se[1])
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: last completed read data and stat counts per DUT.
  logic [31:0] last_rd [2];
  int          n_x     [2];
  int          n_e     [2];

  typedef struct {
    bit          we;
    logic [29:0] addr;
    logic [31:0] wdata;
    bit          hold;
    bit          hit;
    int          slot;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [12];
  logic [127:0] tbl_data;

  task automatic chk(input int d, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL dut%0d %s: got %0h, expected %0h (t=%0t)", d, name, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic longint base_of(input int d);
    return (d == 0) ? 64'd0 : 64'h100;
  endfunction

  function automatic int exp_stat(input int v);
`ifdef MMIO_STATS_EN
    return (v > 65535) ? 65535 : v;
`else
    return 0 * v;
`endif
  endfunction

  // Slot decode from plain integer arithmetic over the address map.
  task automatic decode(input int d, input logic [29:0] a, output bit hit, output int slot);
    longint av;
    longint off;
    av   = longint'(a);
    hit  = 1'b0;
    slot = 0;
    if (av >= base_of(d)) begin
      off = av - base_of(d);
      if ((off % 4 == 0) && (off / 4 < 4)) begin
        hit  = 1'b1;
        slot = int'(off / 4);
      end
    end
  endtask

  // One full transaction with per-cycle checks through one idle cycle after m_done.
  task automatic run_xact(input int d, input bit w, input logic [29:0] a, input logic [31:0] wd,
                          input logic [127:0] good, input bit hold, input bit hit, input int slot,
                          input logic [31:0] exp_rd);
    int kd;
    bit rd_hit;
    logic [3:0] stb;
    stb    = hit ? (4'(1) << slot) : 4'b0;
    rd_hit = hit && !w;
    kd     = !hit ? 1 : (w ? 2 : 2 + lat_of(d));
    n_x[d]++;
    if (!hit) n_e[d]++;

    @(negedge clk);
    req[d]    = 1'b1;
    we_i[d]   = w;
    addr_i[d] = a;
    wd_i[d]   = wd;
    sd[d]     = rd_hit ? ~good : good;

    for (int k = 1; k <= kd + 1; k++) begin
      @(posedge clk);
      #1;
      if (!hold || k > kd) req[d] = 1'b0;
      // Only the cycle whose end is the capture point carries the real data.
      if (rd_hit) sd[d] = (k == 1 + lat_of(d)) ? good : ~good;

      chk(d, "writeEnable", 64'(wen[d]), 64'((w && k == 1) ? stb : 4'b0));
      chk(d, "readEnable", 64'(ren[d]), 64'((!w && k == 1) ? stb : 4'b0));
      chk(d, "m_done", 64'(done[d]), 64'(k == kd));
      if (k == 1 && hit) begin
        chk(d, "memAddress", 64'(maddr[d]), 64'(a));
        chk(d, "writeData", 64'(wdo[d]), 64'(wd));
      end
      if (k <= kd) chk(d, "m_busy", 64'(busy[d]), 64'd1);
      if (k == kd) begin
        chk(d, "m_err", 64'(err[d]), 64'(!hit));
        chk(d, "m_rdata", 64'(rdata[d]), 64'(exp_rd));
      end
      if (k == kd + 1) begin
        chk(d, "m_busy idle", 64'(busy[d]), 64'd0);
        chk(d, "m_rdata held", 64'(rdata[d]), 64'(exp_rd));
        chk(d, "stat_xfers", 64'(sx[d]), 64'(exp_stat(n_x[d])));
        chk(d, "stat_errs", 64'(se[d]), 64'(exp_stat(n_e[d])));
      end
    end
    req[d]     = 1'b0;
    last_rd[d] = exp_rd;
  endtask

  task automatic rand_xact(input int d);
    logic [29:0]  a;
    logic [31:0]  wd;
    logic [31:0]  er;
    logic [127:0] good;
    bit w, hold, hit;
    int slot;
    if ($urandom_range(0, 7) == 0) a = 30'($urandom);
    else begin
      a = 30'(base_of(d)) + 30'($urandom_range(0, 20));
      if (d == 1) a = a - 30'($urandom_range(0, 8));
    end
    w    = 1'($urandom_range(0, 1));
    hold = ($urandom_range(0, 3) == 0);
    wd   = $urandom;
    good = {$urandom, $urandom, $urandom, $urandom};
    decode(d, a, hit, slot);
    er = !hit ? 32'h0 : (w ? last_rd[d] : good[slot*32 +: 32]);
    run_xact(d, w, a, wd, good, hold, hit, slot, er);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 30'h0,         32'h0,        1'b0, 1'b1, 0, 32'h0000_A5A5};
    tbl[1]  = '{1'b1, 30'h4,         32'h1234,     1'b0, 1'b1, 1, 32'h0000_A5A5};
    tbl[2]  = '{1'b0, 30'h6,         32'h0,        1'b0, 1'b0, 0, 32'h0};
    tbl[3]  = '{1'b0, 30'h10,        32'h0,        1'b0, 1'b0, 0, 32'h0};
    tbl[4]  = '{1'b0, 30'hC,         32'h0,        1'b1, 1'b1, 3, 32'h3333_A5A5};
    tbl[5]  = '{1'b1, 30'h8,         32'hDEAD_BEEF, 1'b0, 1'b1, 2, 32'h3333_A5A5};
    tbl[6]  = '{1'b0, 30'h2,         32'h0,        1'b0, 1'b0, 0, 32'h0};
    tbl[7]  = '{1'b0, 30'h3FFF_FFFC, 32'h0,        1'b0, 1'b0, 0, 32'h0};
    tbl[8]  = '{1'b0, 30'h8,         32'h0,        1'b0, 1'b1, 2, 32'h2222_A5A5};
    tbl[9]  = '{1'b1, 30'h10,        32'h55,       1'b0, 1'b0, 0, 32'h0};
    tbl[10] = '{1'b0, 30'h4,         32'h0,        1'b1, 1'b1, 1, 32'h1111_A5A5};
    tbl[11] = '{1'b1, 30'h0,         32'h7777,     1'b0, 1'b1, 0, 32'h1111_A5A5};
    tbl_data = {32'h3333_A5A5, 32'h2222_A5A5, 32'h1111_A5A5, 32'h0000_A5A5};

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we_i[d] = 1'b0; addr_i[d] = '0; wd_i[d] = '0; sd[d] = '0;
      last_rd[d] = '0; n_x[d] = 0; n_e[d] = 0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk(d, "rst m_busy", 64'(busy[d]), 64'd0);
      chk(d, "rst m_done", 64'(done[d]), 64'd0);
      chk(d, "rst m_err", 64'(err[d]), 64'd0);
      chk(d, "rst m_rdata", 64'(rdata[d]), 64'd0);
      chk(d, "rst memAddress", 64'(maddr[d]), 64'd0);
      chk(d, "rst writeData", 64'(wdo[d]), 64'd0);
      chk(d, "rst strobes", 64'({wen[d], ren[d]}), 64'd0);
      chk(d, "rst stats", 64'({sx[d], se[d]}), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors on the zero-latency fabric
    for (int i = 0; i < 12; i++)
      run_xact(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl_data, tbl[i].hold,
               tbl[i].hit, tbl[i].slot, tbl[i].rd);

    // Latency-3 fabric: held request during a read, underflow miss, write
    begin
      logic [127:0] g;
      g = {$urandom, $urandom, $urandom, $urandom};
      run_xact(1, 1'b0, 30'h10C, 32'h0, g, 1'b1, 1'b1, 3, g[127:96]);
      run_xact(1, 1'b0, 30'h0FC, 32'h0, g, 1'b0, 1'b0, 0, 32'h0);
      run_xact(1, 1'b1, 30'h100, 32'hCAFE, g, 1'b0, 1'b1, 0, 32'h0);
      run_xact(1, 1'b0, 30'h104, 32'h0, g, 1'b0, 1'b1, 1, g[63:32]);
    end

    // Reset during the ACCESS cycle of a read aborts it silently
    @(negedge clk);
    req[0] = 1'b1; we_i[0] = 1'b0; addr_i[0] = 30'h0; sd[0] = tbl_data;
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    chk(0, "abort readEnable", 64'(ren[0]), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk(0, "abort m_busy", 64'(busy[0]), 64'd0);
    chk(0, "abort m_done", 64'(done[0]), 64'd0);
    chk(0, "abort m_rdata", 64'(rdata[0]), 64'd0);
    chk(0, "abort strobes", 64'({wen[0], ren[0]}), 64'd0);
    @(posedge clk);
    #1;
    chk(0, "abort no late done", 64'(done[0]), 64'd0);
    for (int d = 0; d < 2; d++) begin
      last_rd[d] = '0; n_x[d] = 0; n_e[d] = 0;
    end
    run_xact(0, 1'b0, 30'h0, 32'h0, tbl_data, 1'b0, 1'b1, 0, 32'h0000_A5A5);

    // Randomized traffic against the model
    repeat (40) rand_xact(0);
    repeat (25) rand_xact(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
